// File: rtl/nios_mem_copier.sv
// nios_mem_copier
// Copies or fills a run of words in a single-port on-chip memory with a
// read latency of one cycle.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_mode          0 = copy, 1 = fill
//   cmd_src/dst/len   source/destination word address, word count
//   cmd_pattern       fill value
//   busy, done        command in progress / one-cycle completion pulse
//   words_done        words written for the current or last command
//   m_*               memory master port (address, byteenable, chipselect,
//                     write, writedata, readdata, clken)
module nios_mem_copier #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mode,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic [DATA_W-1:0]   cmd_pattern,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     words_done,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken
);

    localparam logic [ADDR_W:0]   MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    state_t              state;
    state_t              next_state;
    logic                mode_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;

    logic                accept;
    logic [ADDR_W:0]     len_clamped;
    logic                last_word;

    logic [ADDR_W-1:0]   src_nxt;
    logic [ADDR_W-1:0]   dst_nxt;
    logic                cs_nxt;
    logic                wr_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign m_clken   = 1'b1;

    // Lengths beyond the memory size would only rewrite the same words again.
    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

    // words_done counts completed writes, so the write in progress is the last
    // one when one more completion reaches the latched length.
    assign last_word = ((words_done + COUNT_ONE) == len_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (len_clamped == '0) begin
                        next_state = FIN;
                    end else if (cmd_mode) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD:   next_state = CAP;
            CAP:  next_state = WR;
            WR: begin
                if (last_word) begin
                    next_state = FIN;
                end else if (mode_q) begin
                    next_state = WR;
                end else begin
                    next_state = RD;
                end
            end
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: every memory-side output is registered, so this computes
    // the values they take in the state being entered.  m_writedata doubles
    // as the write buffer: CAP loads it from the memory, a fill command loads
    // the pattern once at acceptance and it is held from then on.
    always_comb begin
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        wdata_nxt = m_writedata;
        if (accept) begin
            src_nxt = cmd_src;
            dst_nxt = cmd_dst;
            if (cmd_mode) begin
                wdata_nxt = cmd_pattern;
            end
        end else if (state == WR && !last_word) begin
            src_nxt = src_ptr + PTR_ONE;
            dst_nxt = dst_ptr + PTR_ONE;
        end
        if (state == CAP) begin
            wdata_nxt = m_readdata;
        end
        cs_nxt   = (next_state == RD) || (next_state == WR);
        wr_nxt   = (next_state == WR);
        addr_nxt = (next_state == RD) ? src_nxt : dst_nxt;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= 1'b0;
            len_q        <= '0;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            words_done   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
        end else begin
            src_ptr      <= src_nxt;
            dst_ptr      <= dst_nxt;
            busy         <= (next_state != IDLE);
            done         <= (next_state == FIN);
            m_chipselect <= cs_nxt;
            m_write      <= wr_nxt;
            m_address    <= addr_nxt;
            m_byteenable <= cs_nxt ? '1 : '0;
            m_writedata  <= wdata_nxt;
            if (accept) begin
                mode_q     <= cmd_mode;
                len_q      <= len_clamped;
                words_done <= '0;
            end else if (state == WR) begin
                words_done <= words_done + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_nios_mem_copier.sv
// tb_nios_mem_copier
// Drives directed copy/fill commands into nios_mem_copier against a
// one-cycle-latency memory and compares every cycle with a word-level model.
module tb_nios_mem_copier;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [10:0] cmd_src;
    logic [10:0] cmd_dst;
    logic [11:0] cmd_len;
    logic [31:0] cmd_pattern;
    logic        busy;
    logic        done;
    logic [11:0] words_done;
    logic [10:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_clken;

    nios_mem_copier #(.ADDR_W(11), .DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode),
        .cmd_src(cmd_src),
        .cmd_dst(cmd_dst),
        .cmd_len(cmd_len),
        .cmd_pattern(cmd_pattern),
        .busy(busy),
        .done(done),
        .words_done(words_done),
        .m_address(m_address),
        .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .m_clken(m_clken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected bus cycle.
    typedef struct {
        logic        cs;
        logic        wr;
        logic [10:0] addr;
        logic [31:0] data;
        logic        dn;
        logic [11:0] words;
        logic        chkBusy;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] gold [0:2047];
    logic [31:0] mem  [0:2047];
    logic [11:0] lastWords;
    int          checks;
    int          errors;

    function automatic logic [31:0] initVal(int i);
        if (i < 4)                    return 32'h0000_000A + i;
        else if (i >= 16 && i <= 18)  return i - 15;
        else                          return (i * 32'h0101_0101) ^ 32'hA500_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory with one-cycle read latency; the only writer of mem.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = initVal(i);
        m_readdata = '0;
        forever begin
            @(posedge clk);
            if (m_chipselect) begin
                if (m_write) mem[m_address] <= m_writedata;
                else         m_readdata     <= mem[m_address];
            end
        end
    end

    // Compare process: one expected entry per busy cycle, idle otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            checkOutput("rst_cs", m_chipselect, 1'b0);
            checkOutput("rst_wr", m_write, 1'b0);
            checkOutput("rst_done", done, 1'b0);
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_ready", cmd_ready, 1'b0);
            checkOutput("rst_words", words_done, 12'd0);
        end else if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cs", m_chipselect, e.cs);
            if (e.cs) begin
                checkOutput("wr", m_write, e.wr);
                checkOutput("addr", m_address, e.addr);
                checkOutput("be", m_byteenable, 4'hF);
                if (e.wr) checkOutput("wdata", m_writedata, e.data);
            end
            checkOutput("done", done, e.dn);
            checkOutput("words", words_done, e.words);
            checkOutput("ready_busy", cmd_ready, 1'b0);
            if (e.chkBusy) checkOutput("busy", busy, 1'b1);
        end else begin
            checkOutput("idle_cs", m_chipselect, 1'b0);
            checkOutput("idle_done", done, 1'b0);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_ready", cmd_ready, 1'b1);
            checkOutput("idle_words", words_done, lastWords);
        end
    end

    // Word-level model: the bus trace and memory image a command must produce.
    task automatic buildModel(input logic mode, input logic [10:0] src, input logic [10:0] dst,
                              input logic [11:0] len, input logic [31:0] pattern);
        int   n;
        exp_t e;
        n = (len > 12'd2048) ? 2048 : int'(len);
        for (int i = 0; i < n; i++) begin
            logic [10:0] s;
            logic [10:0] d;
            s = 11'((int'(src) + i) % 2048);
            d = 11'((int'(dst) + i) % 2048);
            if (!mode) begin
                e = '{cs: 1'b1, wr: 1'b0, addr: s, data: '0, dn: 1'b0, words: 12'(i), chkBusy: 1'b1};
                expQ.push_back(e);
                e = '{cs: 1'b0, wr: 1'b0, addr: '0, data: '0, dn: 1'b0, words: 12'(i), chkBusy: 1'b1};
                expQ.push_back(e);
                gold[d] = gold[s];
            end else begin
                gold[d] = pattern;
            end
            e = '{cs: 1'b1, wr: 1'b1, addr: d, data: gold[d], dn: 1'b0, words: 12'(i), chkBusy: 1'b1};
            expQ.push_back(e);
        end
        e = '{cs: 1'b0, wr: 1'b0, addr: '0, data: '0, dn: 1'b1, words: 12'(n), chkBusy: 1'b0};
        expQ.push_back(e);
        lastWords = 12'(n);
    endtask

    task automatic applyStimulus(input logic mode, input logic [10:0] src, input logic [10:0] dst,
                                 input logic [11:0] len, input logic [31:0] pattern,
                                 input logic holdValid, input logic [11:0] expWords);
        int cyc;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_len     = len;
        cmd_pattern = pattern;
        @(posedge clk);
        #1;
        buildModel(mode, src, dst, len, pattern);
        if (holdValid) begin
            // Junk command held high while busy must be ignored.
            cmd_mode    = ~mode;
            cmd_src     = 11'h7AA;
            cmd_dst     = 11'h055;
            cmd_len     = 12'd5;
            cmd_pattern = 32'hBAD0_BAD0;
        end else begin
            cmd_valid = 1'b0;
        end
        cyc = 0;
        while (expQ.size() != 0 && cyc < 6000) begin
            @(negedge clk);
            if (done) cmd_valid = 1'b0;
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeout actual=%0d required=0 entries left", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
        #1;
        checkOutput("final_words", words_done, expWords);
    endtask

    task automatic checkMem(input string name, input int lo, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            checkOutput(name, mem[(lo + i) % 2048], gold[(lo + i) % 2048]);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        lastWords   = '0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_mode    = 1'b0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_len     = '0;
        cmd_pattern = '0;
        for (int i = 0; i < 2048; i++) gold[i] = initVal(i);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("clken", m_clken, 1'b1);

        // Fill of four words.
        applyStimulus(1'b1, 11'h000, 11'h100, 12'd4, 32'hDEADBEEF, 1'b0, 12'd4);
        checkMem("fill_mem", 'h0FF, 6);
        checkOutput("fill_lit", mem[11'h103], 32'hDEADBEEF);

        // Copy of three words with a junk request held during the command.
        applyStimulus(1'b0, 11'h010, 11'h200, 12'd3, 32'h0, 1'b1, 12'd3);
        checkMem("copy_mem", 'h200, 3);
        checkOutput("copy_lit", mem[11'h202], 32'd3);

        // Overlapping ascending copy replicates the first word.
        applyStimulus(1'b0, 11'h000, 11'h001, 12'd3, 32'h0, 1'b0, 12'd3);
        checkMem("ovl_mem", 0, 4);
        checkOutput("ovl_lit", mem[11'h003], 32'h0000_000A);

        // Fill that wraps past the top of memory.
        applyStimulus(1'b1, 11'h000, 11'h7FE, 12'd3, 32'h5A5A_1234, 1'b0, 12'd3);
        checkMem("wrap_mem", 'h7FD, 4);
        checkOutput("wrap_lit", mem[11'h000], 32'h5A5A_1234);

        // Zero length finishes with no access.
        applyStimulus(1'b1, 11'h000, 11'h300, 12'd0, 32'hFFFF_FFFF, 1'b0, 12'd0);
        checkMem("zero_mem", 'h300, 2);

        // Oversized length is clamped to the full memory.
        applyStimulus(1'b1, 11'h000, 11'h400, 12'hFFF, 32'hC0DE_0001, 1'b0, 12'd2048);
        checkMem("clamp_mem", 'h3FF, 3);

        // Reset during the second word of an eight-word fill.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_mode    = 1'b1;
        cmd_dst     = 11'h300;
        cmd_len     = 12'd8;
        cmd_pattern = 32'h1234_5678;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        buildModel(1'b1, 11'h000, 11'h300, 12'd8, 32'h1234_5678);
        for (int i = 2; i < 8; i++) gold[11'h300 + i] = 32'hC0DE_0001;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        expQ.delete();
        lastWords = '0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_ready", cmd_ready, 1'b1);
        checkMem("abort_mem", 'h300, 8);
        checkOutput("abort_lit", mem[11'h302], 32'hC0DE_0001);

        // New command after the abort completes normally.
        applyStimulus(1'b0, 11'h300, 11'h500, 12'd2, 32'h0, 1'b0, 12'd2);
        checkMem("post_mem", 'h500, 2);
        checkOutput("post_lit", mem[11'h501], 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_mem_copier.md
NIOS_MEM_COPIER -- requirements
Module: nios_mem_copier

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 11, as the word-address width of the target on-chip memory (2048 words).
REQ-002 The block SHALL take parameter DATA_W, default 32, as the memory data width; byteenable width is DATA_W/8.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid & cmd_ready are high on a clk edge.
REQ-007 cmd_mode  in  1  0 = copy, 1 = fill.
REQ-008 cmd_src  in  ADDR_W  copy source word address.
REQ-009 cmd_dst  in  ADDR_W  destination word address.
REQ-010 cmd_len  in  ADDR_W+1  word count.
REQ-011 cmd_pattern  in  DATA_W  fill value.
REQ-012 busy  out  1  high from the cycle after acceptance until done.
REQ-013 done  out  1  one-cycle pulse at end of every accepted command.
REQ-014 words_done  out  ADDR_W+1  words written for the current or last command.
REQ-015 m_address  out  ADDR_W  memory word address.
REQ-016 m_byteenable  out  DATA_W/8  always all ones when m_chipselect is high.
REQ-017 m_chipselect, m_write  out  1 each  access strobe; write when both high, read when m_chipselect high and m_write low.
REQ-018 m_writedata  out  DATA_W; m_readdata  in  DATA_W; m_clken  out  1, tied high.

Function
REQ-019 The target memory SHALL be treated as single-port, read latency 1: read address driven in cycle N, m_readdata sampled in cycle N+1.
REQ-020 All outputs except cmd_ready and m_clken SHALL be registered.
REQ-021 FSM states SHALL be IDLE, RD, CAP, WR, FIN.
REQ-022 IDLE: on acceptance, latch src/dst/len/pattern and clear words_done; if clamped len = 0 go to FIN, else go to RD (copy) or WR (fill).
REQ-023 cmd_len above 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-024 RD SHALL drive a one-cycle read at src pointer, then go to CAP.
REQ-025 CAP SHALL register m_readdata into the write buffer with no memory access, then go to WR.
REQ-026 WR SHALL drive a one-cycle write of buffer (copy) or pattern (fill) at dst pointer and increment words_done.
REQ-027 After WR: if words_done equals len go to FIN; else increment both pointers and go to RD (copy) or stay in WR (fill).
REQ-028 Throughput SHALL be 3 cycles per word in copy mode and 1 cycle per word in fill mode.
REQ-029 Pointers SHALL wrap modulo 2^ADDR_W (2047+1 = 0).
REQ-030 Copy SHALL be strictly ascending word-by-word with no overlap detection; when dst is in (src, src+len), each source word is read after any prior write to it.
REQ-031 FIN SHALL pulse done for one cycle with m_chipselect low, then return to IDLE.
REQ-032 cmd_valid SHALL be ignored while not in IDLE.
REQ-033 At most one memory access SHALL be issued per cycle.
REQ-034 m_chipselect SHALL be low in IDLE, CAP and FIN.

Reset
REQ-035 While reset is high, the state SHALL become IDLE and busy, done, m_chipselect, m_write, words_done and the pointers SHALL be 0.
REQ-036 Reset asserted mid-command SHALL abort it: no done pulse and no further accesses from the next edge on; the partially written region is left as is.
REQ-037 cmd_ready SHALL be 0 while reset is high and 1 on the first cycle after reset deasserts.

Verification
REQ-038 Fill: mode=1, dst=0x100, len=4, pattern=0xDEADBEEF -> 4 consecutive write cycles at 0x100..0x103; done 1 cycle after the last write; words_done=4.
REQ-039 Copy: mem[0x010..0x012]={1,2,3}, src=0x010, dst=0x200, len=3 -> repeating RD,CAP,WR over 9 cycles; mem[0x200..0x202]={1,2,3}; done once.
REQ-040 Wrap: fill with dst=0x7FE, len=3 -> writes at 0x7FE, 0x7FF, 0x000.
REQ-041 Zero/clamp: len=0 -> done the cycle after acceptance with no access; len=0xFFF -> words_done=2048 at done.
REQ-042 Overlap: mem[0..3]={A,B,C,D}, copy src=0, dst=1, len=3 -> mem[0..3]={A,A,A,A}.
REQ-043 Abort: reset asserted during the 2nd word of a len=8 fill -> m_chipselect=0 next cycle, no done, cmd_ready=1 after reset deasserts; a new command then completes normally.
